shift_sequencer: RTL and testbench
==================================

SHIFT_SEQUENCER -- requirements
Module: shift_sequencer

Interface
REQ-001 Parameter WIDTH, default 8, shall set the data path width in bits.
REQ-002 Parameter CNT_W, default 4, shall set the shift-count width in bits.
REQ-003 Port clk, input, 1, shall be the single clock; all state updates on its rising edge.
REQ-004 Port rst_n, input, 1, shall be the asynchronous active-low reset.
REQ-005 Port start, input, 1, shall request an operation; sampled only in IDLE.
REQ-006 Port op, input, 3, shall select the operation: 000 ROL, 001 ROR, 010 SHL, 011 ASR, 100 LSR, 101-111 illegal.
REQ-007 Port data_in, input, WIDTH, shall be the operand, captured with start.
REQ-008 Port count, input, CNT_W, shall give the number of 1-bit steps (0..15), captured with start.
REQ-009 Port result, output, WIDTH, shall be the shifted value, valid when done=1 and held until the next accepted start.
REQ-010 Port carry, output, 1, shall be the last bit shifted or rotated out.
REQ-011 Port err, output, 1, shall flag an illegal op and be valid with done.
REQ-012 Port busy, output, 1, shall be 1 in RUN and DONE.
REQ-013 Port done, output, 1, shall be a one-cycle completion pulse.

Function
REQ-014 FSM states shall be IDLE, RUN and DONE.
REQ-015 In IDLE with start=1, the block shall capture op, data_in and count, clear carry and err, and go to RUN (count>0, legal op) or DONE (count=0 or illegal op).
REQ-016 In RUN, each cycle shall apply one 1-bit step to the working register and decrement the remaining count; after the step that brings the count to 0, the FSM shall go to DONE.
REQ-017 Step semantics: ROL {d[W-2:0],d[W-1]}; ROR {d[0],d[W-1:1]}; SHL d<<1 with zero fill; ASR arithmetic right shift with sign fill; LSR logical right shift with zero fill.
REQ-018 Carry: for ROL and SHL, d[W-1] before the final step; for ROR, ASR and LSR, d[0] before the final step; 0 when count=0.
REQ-019 Latency: start accepted at edge T, done=1 in the cycle after edge T+count+1 (count=0 gives done one cycle after acceptance).
REQ-020 DONE shall last exactly one cycle, assert done, then return to IDLE.
REQ-021 start while busy=1 shall be ignored without side effects.
REQ-022 Illegal op shall go directly to DONE with err=1, result=data_in unchanged, carry=0; count is ignored.
REQ-023 Counts of WIDTH or more shall be honoured step by step: rotates wrap, and shifts saturate to 0x00 (SHL, LSR) or to sign fill (ASR).
REQ-024 start asserted in the DONE cycle shall be ignored; a new start is accepted no earlier than the following IDLE cycle.

Reset
REQ-025 rst_n=0 shall force IDLE and result=0, carry=0, err=0, busy=0, done=0 immediately, including mid-RUN; the partial result shall be discarded.
REQ-026 After rst_n deasserts, the first rising clk edge shall be able to accept start.

Structure
REQ-027 A shared package shall hold the op encodings (OP_ROL..OP_LSR) and the FSM state typedef.
REQ-028 The combinational 1-bit step (REQ-017, REQ-018) shall be a sub-module shift_step with inputs d and op and outputs q and cout; the sequencer shall instantiate it once.

Verification
REQ-029 ROL, data 0x81, count 1 -> result 0x03, carry 1, err 0, done 2 cycles after the start edge.
REQ-030 ASR, data 0x80, count 3 -> result 0xF0, carry 0; LSR, data 0x80, count 8 -> result 0x00, carry 1.
REQ-031 ROR, data 0x01, count 9 -> result 0x80, carry 1, done at T+10.
REQ-032 SHL, data 0x5A, count 0 -> result 0x5A, carry 0, done at T+1; op 110 -> err 1, result equals data_in, done at T+1.
REQ-033 A second start during RUN is ignored and the first result is intact; rst_n pulsed low mid-RUN -> all outputs 0 immediately, no done pulse, and a fresh start completes normally.

Source files
------------

// File: rtl/shift_sequencer_pkg.sv
`default_nettype none
// ============================================================================
// Module   : shift_sequencer_pkg
// Purpose  : Shared definitions for the shift sequencer. It holds the op
//            encodings, the FSM state type and a helper that tells whether
//            an op is legal.
// Ports    : none (package)
// Revision : 1.0 - initial release
// ============================================================================
package shift_sequencer_pkg;

  localparam logic [2:0] OP_ROL = 3'b000;
  localparam logic [2:0] OP_ROR = 3'b001;
  localparam logic [2:0] OP_SHL = 3'b010;
  localparam logic [2:0] OP_ASR = 3'b011;
  localparam logic [2:0] OP_LSR = 3'b100;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  // Encodings above OP_LSR are reserved.
  function automatic logic op_is_legal(input logic [2:0] op);
    return (op <= OP_LSR);
  endfunction

endpackage
`default_nettype wire

// File: rtl/shift_sequencer_step.sv
`default_nettype none
// ============================================================================
// Module   : shift_step
// Purpose  : Single-step combinational shifter/rotator. It applies a 1-bit
//            step to d and reports the bit that leaves the word.
// Ports    : d    [WIDTH-1:0] in  - operand
//            op   [2:0]       in  - operation select
//            q    [WIDTH-1:0] out - stepped value
//            cout             out - bit shifted or rotated out
// Revision : 1.0 - initial release
// ============================================================================
module shift_step
  import shift_sequencer_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] d,
  input  logic [2:0]       op,
  output logic [WIDTH-1:0] q,
  output logic             cout
);

  always_comb begin
    q    = d;
    cout = 1'b0;
    case (op)
      OP_ROL: begin q = {d[WIDTH-2:0], d[WIDTH-1]}; cout = d[WIDTH-1]; end
      OP_ROR: begin q = {d[0], d[WIDTH-1:1]};       cout = d[0];       end
      OP_SHL: begin q = {d[WIDTH-2:0], 1'b0};       cout = d[WIDTH-1]; end
      OP_ASR: begin q = {d[WIDTH-1], d[WIDTH-1:1]}; cout = d[0];       end
      OP_LSR: begin q = {1'b0, d[WIDTH-1:1]};       cout = d[0];       end
      default: begin q = d; cout = 1'b0; end
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/shift_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : shift_sequencer
// Purpose  : Multi-cycle shifter. It captures an operand, an op and a step
//            count, then applies one 1-bit step per clock. When the count
//            runs out it pulses done for one cycle.
// Ports    : clk, rst_n             - clock, async active-low reset
//            start                  - request (sampled only in IDLE)
//            op [2:0]               - ROL/ROR/SHL/ASR/LSR, others illegal
//            data_in [WIDTH-1:0]    - operand
//            count [CNT_W-1:0]      - number of 1-bit steps
//            result [WIDTH-1:0]     - shifted value, held until next start
//            carry                  - last bit shifted/rotated out
//            err                    - illegal op flag, valid with done
//            busy                   - high in RUN and DONE
//            done                   - one-cycle completion pulse
// Revision : 1.0 - initial release
// ============================================================================
module shift_sequencer
  import shift_sequencer_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int CNT_W = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] data_in,
  input  logic [CNT_W-1:0] count,
  output logic [WIDTH-1:0] result,
  output logic             carry,
  output logic             err,
  output logic             busy,
  output logic             done
);

  localparam logic [CNT_W-1:0] c_cnt_one = CNT_W'(1);

  state_t           r_state;
  state_t           w_next;
  logic [WIDTH-1:0] r_data;
  logic [2:0]       r_op;
  logic [CNT_W-1:0] r_cnt;
  logic             r_carry;
  logic             r_err;
  logic [WIDTH-1:0] w_q;
  logic             w_cout;

  shift_step #(.WIDTH(WIDTH)) u_step (
    .d    (r_data),
    .op   (r_op),
    .q    (w_q),
    .cout (w_cout)
  );

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= ST_IDLE;
    else        r_state <= w_next;
  end

  // Next-state logic. A zero count or an illegal op skips RUN, so there is
  // no step and the captured operand is reported unchanged.
  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE: begin
        if (start) begin
          if (!op_is_legal(op) || (count == '0)) w_next = ST_DONE;
          else                                   w_next = ST_RUN;
        end
      end
      ST_RUN:  if (r_cnt == c_cnt_one) w_next = ST_DONE;
      ST_DONE: w_next = ST_IDLE;
      default: w_next = ST_IDLE;
    endcase
  end

  // Output decode
  always_comb begin
    busy = (r_state == ST_RUN) || (r_state == ST_DONE);
    done = (r_state == ST_DONE);
  end

  // Datapath. The working register is also the visible result. It only
  // changes on capture and in RUN, so it holds through DONE and IDLE.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_data  <= '0;
      r_op    <= OP_ROL;
      r_cnt   <= '0;
      r_carry <= 1'b0;
      r_err   <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (start) begin
            r_data  <= data_in;
            r_op    <= op;
            r_cnt   <= count;
            r_carry <= 1'b0;
            r_err   <= !op_is_legal(op);
          end
        end
        ST_RUN: begin
          r_data  <= w_q;
          r_carry <= w_cout;
          r_cnt   <= r_cnt - c_cnt_one;
        end
        default: ;
      endcase
    end
  end

  assign result = r_data;
  assign carry  = r_carry;
  assign err    = r_err;

endmodule
`default_nettype wire

// File: tb/tb_shift_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_shift_sequencer
// Purpose  : Self-checking bench for shift_sequencer. A scoreboard queue
//            holds the expected result of each accepted request.
// Ports    : none
// Revision : 1.0 - initial release
// ============================================================================
module tb_shift_sequencer;
  import shift_sequencer_pkg::*;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic [2:0] op = 3'b000;
  logic [7:0] data_in = 8'h00;
  logic [3:0] count = 4'h0;
  logic [7:0] result;
  logic       carry, err, busy, done;

  int n_checks = 0;
  int n_pass   = 0;

  typedef struct {
    logic [7:0] res;
    logic       cy;
    logic       er;
    int         lat;
  } exp_t;

  exp_t sb[$];

  shift_sequencer #(.WIDTH(8), .CNT_W(4)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .start   (start),
    .op      (op),
    .data_in (data_in),
    .count   (count),
    .result  (result),
    .carry   (carry),
    .err     (err),
    .busy    (busy),
    .done    (done)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  // Reference model, written step by step, independent of the RTL form.
  function automatic exp_t model(input logic [2:0] o, input logic [7:0] d, input logic [3:0] c);
    exp_t e;
    logic [7:0] v = d;
    logic cy = 1'b0;
    e.er = (o > 3'd4);
    e.lat = (e.er || c == 0) ? 1 : int'(c) + 1;
    if (!e.er) begin
      for (int i = 0; i < int'(c); i++) begin
        case (o)
          3'd0: begin cy = v[7]; v = (v << 1) | (v >> 7); end
          3'd1: begin cy = v[0]; v = (v >> 1) | (v << 7); end
          3'd2: begin cy = v[7]; v = v << 1; end
          3'd3: begin cy = v[0]; v = 8'($signed(v) >>> 1); end
          default: begin cy = v[0]; v = v >> 1; end
        endcase
      end
    end
    e.res = v;
    e.cy = cy;
    return e;
  endfunction

  // One request. Latency counts negedges after the accepting edge until
  // done is seen. Optionally a second start is poked while busy. Start is
  // also raised in the DONE cycle, where it must be ignored.
  task automatic run_op(input string tag, input logic [2:0] o, input logic [7:0] d,
                        input logic [3:0] c, input bit poke);
    exp_t e;
    int n;
    sb.push_back(model(o, d, c));
    @(negedge clk);
    start = 1'b1; op = o; data_in = d; count = c;
    @(negedge clk);
    start = 1'b0;
    n = 1;
    while (done !== 1'b1 && n < 40) begin
      if (poke && n == 2) begin
        start = 1'b1; op = OP_SHL; data_in = 8'hFF; count = 4'd1;
      end
      @(negedge clk);
      start = 1'b0;
      n++;
    end
    e = sb.pop_front();
    if (done !== 1'b1) begin
      check({tag, "_timeout"}, 0, 1);
    end else begin
      check({tag, "_result"}, 32'(result), 32'(e.res));
      check({tag, "_carry"},  32'(carry),  32'(e.cy));
      check({tag, "_err"},    32'(err),    32'(e.er));
      check({tag, "_lat"},    32'(n),      32'(e.lat));
      check({tag, "_busy"},   32'(busy),   32'd1);
      start = 1'b1; op = OP_SHL; data_in = 8'h77; count = 4'd0;
      @(negedge clk);
      start = 1'b0;
      check({tag, "_idle_after"}, {30'd0, busy, done}, 32'd0);
      check({tag, "_held"}, 32'(result), 32'(e.res));
    end
  endtask

  initial begin
    int seen;
    #12;
    check("rst_outputs", {21'd0, result, carry, err, busy, done}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    run_op("rol_81_1",  OP_ROL, 8'h81, 4'd1,  1'b0);
    run_op("asr_80_3",  OP_ASR, 8'h80, 4'd3,  1'b0);
    run_op("lsr_80_8",  OP_LSR, 8'h80, 4'd8,  1'b0);
    run_op("ror_01_9",  OP_ROR, 8'h01, 4'd9,  1'b1);
    run_op("shl_5a_0",  OP_SHL, 8'h5A, 4'd0,  1'b0);
    run_op("ill_110",   3'b110, 8'h3C, 4'd5,  1'b0);
    run_op("shl_ff_15", OP_SHL, 8'hFF, 4'd15, 1'b0);
    run_op("asr_80_15", OP_ASR, 8'h80, 4'd15, 1'b0);
    run_op("rol_a5_12", OP_ROL, 8'hA5, 4'd12, 1'b1);
    run_op("ill_111",   3'b111, 8'hC3, 4'd0,  1'b0);

    // Reset pulse in the middle of a run
    @(negedge clk);
    start = 1'b1; op = OP_ROL; data_in = 8'h81; count = 4'd9;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    #2 rst_n = 1'b0;
    #1 check("rst_mid_run", {21'd0, result, carry, err, busy, done}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    seen = 0;
    repeat (12) begin
      @(negedge clk);
      if (done === 1'b1) seen++;
    end
    check("no_done_after_rst", seen, 0);
    run_op("after_rst", OP_ROR, 8'h96, 4'd3, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
